// File: rtl/reset_debouncer.sv
// reset_debouncer
//   Board-level reset front-end for the SoC. Synchronises and debounces the
//   raw push-button, generates a fixed-length power-on reset, and stretches
//   every clean button press into a SoC reset of guaranteed minimum width.
//
//   There is no valid/ready handshake in this block. The button is a level
//   input. The strobes are one-cycle, registered, and always accepted.
//
// Ports
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   button_in     in   raw asynchronous active-high button
//   sys_reset_o   out  active-high reset to the SoC (registered)
//   button_level  out  debounced button level
//   press_pulse   out  one-cycle strobe on debounced 0->1
//   release_pulse out  one-cycle strobe on debounced 1->0
//   dbg_state     out  current FSM state (0=POR, 1=RUN, 2=HOLD)
module reset_debouncer #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int POR_CYCLES      = 20,
   parameter int PULSE_CYCLES    = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       button_in,
   output logic       sys_reset_o,
   output logic       button_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic [1:0] dbg_state
);

   localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int POR_W   = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
   localparam int PULSE_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

   localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [POR_W-1:0]   POR_MAX   = POR_W'(POR_CYCLES - 1);
   localparam logic [PULSE_W-1:0] PULSE_MAX = PULSE_W'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_POR  = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   logic [SYNC_STAGES-1:0] sync_ff;
   logic                   sync_q;
   logic [DEB_W-1:0]       deb_cnt;

   state_e                 state, state_nxt;
   logic [POR_W-1:0]       por_cnt, por_nxt;
   logic [PULSE_W-1:0]     pulse_cnt, pulse_nxt;

   // Synchroniser chain. Only the last stage is used downstream.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], button_in};
      end
   end

   assign sync_q = sync_ff[SYNC_STAGES-1];

   // Debouncer. The count restarts whenever the synchronised level agrees with
   // the accepted level, so a glitch that is too short leaves nothing behind.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_cnt       <= '0;
         button_level  <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         if (sync_q == button_level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_MAX) begin
            button_level  <= sync_q;
            press_pulse   <= sync_q;
            release_pulse <= ~sync_q;
            deb_cnt       <= '0;
         end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
         end
      end
   end

   // FSM state and counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_POR;
         por_cnt     <= '0;
         pulse_cnt   <= '0;
         sys_reset_o <= 1'b1;
      end else begin
         state       <= state_nxt;
         por_cnt     <= por_nxt;
         pulse_cnt   <= pulse_nxt;
         // Registered from the next state so the output has no decode glitches.
         sys_reset_o <= (state_nxt != ST_RUN);
      end
   end

   // Both counters stop at their maximum. They never wrap.
   always_comb begin
      state_nxt = state;
      por_nxt   = por_cnt;
      pulse_nxt = pulse_cnt;
      case (state)
         ST_POR: begin
            if (por_cnt == POR_MAX) begin
               state_nxt = button_level ? ST_HOLD : ST_RUN;
               pulse_nxt = '0;
            end else begin
               por_nxt = por_cnt + POR_W'(1);
            end
         end
         ST_RUN: begin
            if (press_pulse) begin
               state_nxt = ST_HOLD;
               pulse_nxt = '0;
            end
         end
         ST_HOLD: begin
            // A press strobe arriving here is ignored. The hold is extended only
            // by the debounced level staying high.
            if (pulse_cnt == PULSE_MAX) begin
               if (!button_level) begin
                  state_nxt = ST_RUN;
               end
            end else begin
               pulse_nxt = pulse_cnt + PULSE_W'(1);
            end
         end
         default: begin
            state_nxt = ST_POR;
         end
      endcase
   end

   assign dbg_state = state;

endmodule

// File: doc/reset_debouncer.md
# reset_debouncer

Board-level reset front-end between the raw push-button pin and the `Baby_Risco_5_SOC` reset input. It synchronises and debounces the button, generates a power-on reset of fixed length, and turns each clean button press into a SoC reset of guaranteed minimum width. It also exports the debounced level and one-cycle press/release strobes for GPIO or debug use. It runs in the same clock domain as the SoC.

## Interface

- `SYNC_STAGES`, 2: synchroniser flops on `button_in`; legal range ≥2.
- `DEBOUNCE_CYCLES`, 1000000: consecutive cycles a new synchronised level must hold before it is accepted; legal range ≥2.
- `POR_CYCLES`, 20: cycles `sys_reset_o` stays high after `reset_n` deasserts; legal range ≥1.
- `PULSE_CYCLES`, 16: minimum width of a button-initiated reset; legal range ≥1.

- `clk`  input  1  system clock, rising-edge.
- `reset_n`  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `button_in`  input  1  raw, asynchronous, active-high button.
- `sys_reset_o`  output  1  active-high reset to the SoC.
- `button_level`  output  1  debounced button level.
- `press_pulse`  output  1  one-cycle strobe on debounced 0→1.
- `release_pulse`  output  1  one-cycle strobe on debounced 1→0.

## Operation

- **Reset (`reset_n`=0, asynchronous).** Clears the synchroniser, debounce counter, `button_level`, both strobes and the pulse counter. Sets the FSM to POR with the POR counter at 0. Forces `sys_reset_o`=1.
- **Synchroniser.** `SYNC_STAGES` flops in series. Only the last stage (`sync_q`) is used downstream.
- **Debouncer.**
  - Counter width is $clog2(DEBOUNCE_CYCLES).
  - If `sync_q`==`button_level`, the counter is cleared to 0.
  - Otherwise, while the counter is below DEBOUNCE_CYCLES-1, it increments.
  - On an edge where the counter equals DEBOUNCE_CYCLES-1 and `sync_q` still differs: `button_level`<=`sync_q` and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles is discarded, and its count is lost.
  - `press_pulse` and `release_pulse` are registered and assert on the same edge that `button_level` changes. They are high for exactly one cycle.
- **FSM (state encoding is free).**
  - POR: `sys_reset_o`=1. The counter increments each edge. On the edge where it reaches POR_CYCLES-1, go to HOLD if `button_level`=1, else go to RUN.
  - RUN: `sys_reset_o`=0. If `press_pulse`=1, go to HOLD and clear the pulse counter.
  - HOLD: `sys_reset_o`=1. The pulse counter saturates at PULSE_CYCLES-1. Go to RUN on the edge where the counter equals PULSE_CYCLES-1 and `button_level`=0.
  - HOLD therefore lasts at least PULSE_CYCLES cycles and continues while the button stays held.
- The debouncer keeps running in every state, including POR and HOLD.
- A press strobe seen while in HOLD is ignored.
- Counter widths are sized from their parameters. No counter may wrap.

## Timing

- Reset values: `sys_reset_o`=1; `button_level`=0; `press_pulse`=0; `release_pulse`=0.
- POR after reset: `reset_n` rises before edge 1. `sys_reset_o` falls on edge POR_CYCLES.
- Debounce latency: `button_in` rises before edge 1 and stays high. `button_level` and `press_pulse` rise on edge SYNC_STAGES+DEBOUNCE_CYCLES. Release behaves symmetrically.
- Press to reset: `sys_reset_o` rises one edge after `press_pulse`.
- Reset deassertion from HOLD: `sys_reset_o` falls on the later of two edges:
  - the PULSE_CYCLES-th edge after it rose;
  - the edge after `release_pulse`.
- All outputs are registered. No combinational path runs from `button_in` to any output.
- If `reset_n` asserts mid-operation, all outputs return to their reset values immediately, without waiting for `clk`.

## Test plan

Parameters for all scenarios: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, POR_CYCLES=20, PULSE_CYCLES=8.

- **POR:** hold `reset_n` low 5 cycles, then release with the button low → `sys_reset_o`=1 during reset and for edges 1–19; 0 from edge 20.
- **Glitch rejection:** after POR, pulse `button_in` high for 3 cycles → `button_level`, `press_pulse` and `sys_reset_o` all stay 0.
- **Short press:** `button_in` high for 10 cycles, then low.
  - `press_pulse` is high on edge 6 only.
  - `sys_reset_o` is high from edge 7 to edge 15.
  - `release_pulse` fires at edge 16 (release +6); `sys_reset_o` falls on the later of edge 15 and edge 17 → edge 17.
- **Long hold:** `button_in` high for 50 cycles → `sys_reset_o` stays high until the edge after `release_pulse`, and the pulse counter does not wrap.
- **Button held through POR:** button high from reset → FSM goes POR→HOLD; `sys_reset_o` never drops at edge 20 and falls only after release is debounced.
- **Async reset mid-HOLD:** drive `reset_n` low while in HOLD → all outputs take their reset values without a clock edge; after release, the POR sequence repeats exactly.
